uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive end of the serial link driven by the design's uart_tx pin.
- Synchronises the asynchronous rx line and samples each bit at mid-bit using a cycle counter.
- Presents each received byte on a valid/ready output interface.
- Flags framing errors and overruns. Sits between the FPGA rx pin and the project's command/loopback logic.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit period (12 MHz / 115200); legal range 4..65535
CNT_W, 16, counter width; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk_i  input  1  system clock, single clock domain
rst_i  input  1  asynchronous active-high reset
rx_i  input  1  raw serial line, idle high, asynchronous to clk_i
data_o  output  8  received byte, LSB = first data bit
valid_o  output  1  data_o holds an unconsumed byte
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: byte completed while previous byte unconsumed
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1) values:
  - sync flops = 1, state = IDLE, counter = 0, shift register = 0.
  - data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
- rx_i passes through a 2-flop synchroniser; rxs is the synchronised value. All decisions use rxs. The pin-to-rxs delay is 2 cycles.
- IDLE: when rxs = 0, go to START and clear the counter.
- START: count up to HALF = (CLKS_PER_BIT-1)/2, then sample rxs.
  - rxs = 0: go to DATA, clear the counter and bit index.
  - rxs = 1: glitch; return to IDLE with no outputs.
- DATA: when the counter reaches CLKS_PER_BIT-1, sample rxs into shift register bit[idx] (LSB first) and clear the counter.
  - After idx = 7 is sampled, go to STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
  - rxs = 1: byte complete; go to IDLE immediately (mid-stop-bit) so back-to-back frames resync on the next start edge.
  - rxs = 0: pulse frame_err_o, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs = 1, then go to IDLE. A held break (line low) produces exactly one frame_err_o pulse, not repeated frames.
- Byte-complete handling, evaluated in the cycle the stop bit is sampled:
  - valid_o = 0, or valid_o && ready_i in this same cycle: load data_o and set valid_o next cycle. No overrun.
  - valid_o && !ready_i: keep the old data_o and valid_o, drop the new byte, pulse overrun_o.
- Handshake:
  - valid_o, once set, stays high and data_o stays stable until a cycle with ready_i = 1.
  - valid_o clears on the cycle after acceptance unless a new byte loads in that same cycle.
- Latency: valid_o rises 2 + HALF + 9*CLKS_PER_BIT + 1 cycles after the rx_i falling edge of the start bit. It is cycle-exact given the synchroniser alignment.
- The counter never exceeds CLKS_PER_BIT-1. The bit index wraps only via the DATA→STOP transition.
- rx_i activity in IDLE while valid_o is pending still starts reception.
- Reset mid-frame aborts reception with no pulses. After release the receiver waits in IDLE for the next falling edge; a line still low after reset is treated as a start edge.
- frame_err_o and overrun_o are never high together. Each is high for exactly 1 cycle per event.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH}
  - DATA_BITS = 8
  - default CLKS_PER_BIT constant, shared with the transmitter
- One sub-module: sync_2ff (2-flop synchroniser, configurable reset value, here 1), reusable for other async pins.
- FSM, counter and output register stay in uart_rx.

Test Plan (CLKS_PER_BIT=16 in sim):
- Single frame 0xA5, ready_i=1 → valid_o for 1 cycle with data_o=0xA5 at the computed latency (2+7+144+1 = 154 cycles after the start edge); no error pulses.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, ready_i=1 → three valid_o beats with those exact values in order.
- 4-cycle low glitch on an idle line → returns to IDLE; no valid_o, busy_o high for at most HALF+3 cycles.
- Frame 0x3C with stop bit low, then line held low 100 cycles, then high → exactly one frame_err_o pulse, no valid_o; next good frame 0x81 is received correctly.
- ready_i=0; send 0x11 then 0x22 → valid_o high with data_o=0x11, one overrun_o pulse at the second stop sample. Raising ready_i then accepts 0x11 and valid_o drops.
- Assert rst_i during DATA bit 4 of a frame → all outputs 0 immediately; after release a fresh frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry, default bit timing.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned IDX_W            = $clog2(DATA_BITS);
    // 12 MHz / 115200 baud, shared with the transmitter
    localparam int unsigned CLKS_PER_BIT_DEF = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // shift the pin through two stages
    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    // synchroniser flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 half_c;
    logic                 bit_end_c;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    assign half_c    = (cnt_q == HALF);
    assign bit_end_c = (cnt_q == LAST);

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!rxs) state_d = START;
            START:     if (half_c) state_d = rxs ? IDLE : DATA;
            DATA:      if (bit_end_c && (idx_q == IDX_LAST)) state_d = STOP;
            STOP:      if (bit_end_c) state_d = rxs ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // counter, shift register and output register next values
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !ready_i;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            START: begin
                if (half_c) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || ready_i) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = (CPB - 1) / 2;
    localparam int unsigned LAT  = 2 + HALF + 9 * CPB + 1;   // 154

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       ov;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (fe),
        .overrun_o   (ov),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // observed activity, sampled on the falling edge
    logic [7:0] beats[$];
    int   fe_cnt, ov_cnt, both_cnt, valid_hi, busy_hi;
    int   rise_cyc, ov_cyc, start_cyc;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) beats.push_back(data);
            if (valid && !valid_prev) rise_cyc = cyc;
            if (valid) valid_hi++;
            if (busy) busy_hi++;
            if (fe) fe_cnt++;
            if (ov) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if (fe && ov) both_cnt++;
        end
        valid_prev = valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick_n(CPB);
    endtask

    // start_cyc = first clock edge that samples the low start bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic clr_mon();
        beats.delete();
        fe_cnt   = 0;
        ov_cnt   = 0;
        valid_hi = 0;
        busy_hi  = 0;
        rise_cyc = -1;
        ov_cyc   = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        both_cnt = 0;
        clr_mon();
        rx    = 1'b1;
        ready = 1'b1;
        rst   = 1'b0;
        #1 rst = 1'b1;
        tick_n(3);
        check_eq("rst_data",  32'(data),  32'h0);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_fe",    32'(fe),    32'h0);
        check_eq("rst_ov",    32'(ov),    32'h0);
        check_eq("rst_busy",  32'(busy),  32'h0);
        rst = 1'b0;
        tick_n(CPB);

        // single frame, latency
        clr_mon();
        send_frame(8'hA5, 1'b1);
        tick_n(CPB);
        check_eq("t1_beats",   32'(beats.size()), 32'd1);
        check_eq("t1_data",    32'(beats[0]),     32'hA5);
        check_eq("t1_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        check_eq("t1_valid_w", 32'(valid_hi),     32'd1);
        check_eq("t1_fe",      32'(fe_cnt),       32'd0);
        check_eq("t1_ov",      32'(ov_cnt),       32'd0);

        // back-to-back frames
        clr_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        tick_n(CPB);
        check_eq("t2_beats", 32'(beats.size()), 32'd3);
        check_eq("t2_b0",    32'(beats[0]),     32'h00);
        check_eq("t2_b1",    32'(beats[1]),     32'hFF);
        check_eq("t2_b2",    32'(beats[2]),     32'h55);
        check_eq("t2_fe",    32'(fe_cnt),       32'd0);

        // short glitch
        clr_mon();
        rx = 1'b0;
        tick_n(4);
        rx = 1'b1;
        tick_n(2 * CPB);
        check_eq("t3_busy_seen", 32'(busy_hi > 0),           32'd1);
        check_eq("t3_busy_max",  32'(busy_hi <= HALF + 3),   32'd1);
        check_eq("t3_beats",     32'(beats.size()),          32'd0);
        check_eq("t3_fe",        32'(fe_cnt),                32'd0);
        check_eq("t3_busy_end",  32'(busy),                  32'd0);

        // framing error followed by a held break
        clr_mon();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        tick_n(100);
        rx = 1'b1;
        tick_n(2 * CPB);
        check_eq("t4_fe",    32'(fe_cnt),       32'd1);
        check_eq("t4_beats", 32'(beats.size()), 32'd0);
        send_frame(8'h81, 1'b1);
        tick_n(CPB);
        check_eq("t4_beats2", 32'(beats.size()), 32'd1);
        check_eq("t4_data2",  32'(beats[0]),     32'h81);
        check_eq("t4_fe2",    32'(fe_cnt),       32'd1);

        // overrun with consumer stalled
        clr_mon();
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick_n(CPB);
        check_eq("t5_valid",  32'(valid),  32'd1);
        check_eq("t5_data",   32'(data),   32'h11);
        check_eq("t5_ov",     32'(ov_cnt), 32'd1);
        check_eq("t5_ov_cyc", 32'(ov_cyc - start_cyc), 32'(LAT));
        check_eq("t5_fe",     32'(fe_cnt), 32'd0);
        ready = 1'b1;
        tick_n(2);
        check_eq("t5_valid_off", 32'(valid),         32'd0);
        check_eq("t5_beats",     32'(beats.size()),  32'd1);
        check_eq("t5_acc_data",  32'(beats[0]),      32'h11);

        // reset in the middle of data bit 4
        clr_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        tick_n(CPB / 2);
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_data",  32'(data),  32'h0);
        check_eq("t6_valid", 32'(valid), 32'h0);
        check_eq("t6_busy",  32'(busy),  32'h0);
        check_eq("t6_fe",    32'(fe),    32'h0);
        check_eq("t6_ov",    32'(ov),    32'h0);
        tick_n(2);
        rx  = 1'b1;
        rst = 1'b0;
        tick_n(2 * CPB);
        send_frame(8'hC3, 1'b1);
        tick_n(CPB);
        check_eq("t6_beats", 32'(beats.size()), 32'd1);
        check_eq("t6_rx",    32'(beats[0]),     32'hC3);
        check_eq("t6_fe_n",  32'(fe_cnt),       32'd0);
        check_eq("t6_ov_n",  32'(ov_cnt),       32'd0);

        check_eq("fe_ov_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
